// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order register-file writeback FIFO with a registered write stage and
// combinational read-after-write forwarding from pending entries.
module reg_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_valid,
    input  logic [2:0]                    wb_addr,
    input  logic [7:0]                    wb_data,
    output logic                          wb_ready,
    input  logic                          rf_hold,
    output logic [2:0]                    rf_write_reg,
    output logic                          rf_write_signal,
    output logic [7:0]                    rf_in_data,
    input  logic [2:0]                    rd_addr_1,
    input  logic [2:0]                    rd_addr_2,
    output logic                          fwd_hit_1,
    output logic                          fwd_hit_2,
    output logic [7:0]                    fwd_data_1,
    output logic [7:0]                    fwd_data_2,
    output logic [$clog2(DEPTH+2)-1:0]    pending,
    output logic                          idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(DEPTH + 2);

    logic [2:0]    addr_mem_q [DEPTH];
    logic [7:0]    data_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    reg_q, reg_d;
    logic [7:0]    dat_q, dat_d;
    logic          push, pop;

    assign wb_ready = cnt_q != CW'(DEPTH);

    // Writes to R0 complete the handshake but are dropped, since R0 is hardwired to zero.
    always_comb begin
        push     = wb_valid && wb_ready && wb_addr != 3'd0;
        pop      = cnt_q != '0 && !rf_hold;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        we_d     = pop;
        reg_d    = pop ? addr_mem_q[rd_ptr_q] : reg_q;
        dat_d    = pop ? data_mem_q[rd_ptr_q] : dat_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            reg_q    <= '0;
            dat_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            reg_q    <= reg_d;
            dat_q    <= dat_d;
        end
    end

    // Entry storage needs no reset: validity is governed entirely by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= wb_addr;
            data_mem_q[wr_ptr_q] <= wb_data;
        end
    end

    // Output stage has lowest priority; scanning oldest to youngest lets the youngest match win.
    function automatic logic [8:0] fwd(input logic [2:0] a);
        logic [8:0] r;
        r = (a != 3'd0 && we_q && reg_q == a) ? {1'b1, dat_q} : 9'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a != 3'd0 && i < int'(cnt_q) && addr_mem_q[rd_ptr_q + PW'(i)] == a)
                r = {1'b1, data_mem_q[rd_ptr_q + PW'(i)]};
        end
        return r;
    endfunction

    assign {fwd_hit_1, fwd_data_1} = fwd(rd_addr_1);
    assign {fwd_hit_2, fwd_data_2} = fwd(rd_addr_2);

    assign rf_write_signal = we_q;
    assign rf_write_reg    = reg_q;
    assign rf_in_data      = dat_q;
    assign pending         = NW'(cnt_q) + NW'(we_q);
    assign idle            = cnt_q == '0 && !we_q;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed checks of enqueue, drain order, full/empty, forwarding and reset.
module tb_reg_writeback_queue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wb_valid = 1'b0;
    logic [2:0] wb_addr = '0;
    logic [7:0] wb_data = '0;
    logic       wb_ready;
    logic       rf_hold = 1'b0;
    logic [2:0] rf_write_reg;
    logic       rf_write_signal;
    logic [7:0] rf_in_data;
    logic [2:0] rd_addr_1 = '0;
    logic [2:0] rd_addr_2 = '0;
    logic       fwd_hit_1, fwd_hit_2;
    logic [7:0] fwd_data_1, fwd_data_2;
    logic [2:0] pending;
    logic       idle;
    int         errors = 0;
    int         checks = 0;

    reg_writeback_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_ready(wb_ready), .rf_hold(rf_hold), .rf_write_reg(rf_write_reg),
        .rf_write_signal(rf_write_signal), .rf_in_data(rf_in_data),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2), .pending(pending), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [2:0] r, input logic [7:0] d);
        chk({tag, "_we"}, rf_write_signal, 1'b1);
        chk({tag, "_reg"}, rf_write_reg, r);
        chk({tag, "_data"}, rf_in_data, d);
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_ready", wb_ready, 1'b1);
        chk("rst_pending", pending, 3'd0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_we", rf_write_signal, 1'b0);
        tick();
        rst = 1'b0;

        // single write, latency and idle return
        push(3'd3, 8'h5A);
        chk("p1_pending", pending, 3'd1);
        chk("p1_idle", idle, 1'b0);
        chk("p1_we", rf_write_signal, 1'b0);
        rd_addr_1 = 3'd3;
        #1;
        chk("p1_fwdq_hit", fwd_hit_1, 1'b1);
        chk("p1_fwdq_data", fwd_data_1, 8'h5A);
        tick();
        wr("p1_out", 3'd3, 8'h5A);
        chk("p1_fwdo_hit", fwd_hit_1, 1'b1);
        chk("p1_fwdo_data", fwd_data_1, 8'h5A);
        tick();
        chk("p1_we_off", rf_write_signal, 1'b0);
        chk("p1_idle2", idle, 1'b1);
        chk("p1_reg_hold", rf_write_reg, 3'd3);
        chk("p1_data_hold", rf_in_data, 8'h5A);
        chk("p1_fwd_gone", fwd_hit_1, 1'b0);

        // R0 write discarded
        chk("r0_ready", wb_ready, 1'b1);
        push(3'd0, 8'hFF);
        chk("r0_pending", pending, 3'd0);
        chk("r0_idle", idle, 1'b1);
        tick();
        chk("r0_we", rf_write_signal, 1'b0);

        // fill under hold, forwarding youngest-first
        rf_hold = 1'b1;
        push(3'd1, 8'h11);
        push(3'd2, 8'h22);
        push(3'd1, 8'h33);
        push(3'd5, 8'h55);
        chk("full_ready", wb_ready, 1'b0);
        chk("full_pending", pending, 3'd4);
        chk("full_we", rf_write_signal, 1'b0);
        rd_addr_1 = 3'd1;
        rd_addr_2 = 3'd5;
        #1;
        chk("fwd1_hit", fwd_hit_1, 1'b1);
        chk("fwd1_data", fwd_data_1, 8'h33);
        chk("fwd2_data", fwd_data_2, 8'h55);
        rd_addr_1 = 3'd7;
        rd_addr_2 = 3'd2;
        #1;
        chk("fwd_miss_hit", fwd_hit_1, 1'b0);
        chk("fwd_miss_data", fwd_data_1, 8'h00);
        chk("fwd2b_data", fwd_data_2, 8'h22);
        rd_addr_1 = 3'd0;
        #1;
        chk("fwd_r0_hit", fwd_hit_1, 1'b0);
        rf_hold = 1'b0;
        rd_addr_1 = 3'd1;
        tick();
        wr("d1", 3'd1, 8'h11);
        chk("d1_pending", pending, 3'd4);
        chk("d1_fwd", fwd_data_1, 8'h33);
        tick();
        wr("d2", 3'd2, 8'h22);
        tick();
        wr("d3", 3'd1, 8'h33);
        tick();
        wr("d4", 3'd5, 8'h55);
        chk("d4_pending", pending, 3'd1);
        tick();
        chk("d5_we", rf_write_signal, 1'b0);
        chk("d5_idle", idle, 1'b1);

        // full with pop: push blocked one edge, then accepted; pointers wrap
        rf_hold = 1'b1;
        push(3'd1, 8'hA1);
        push(3'd2, 8'hA2);
        push(3'd3, 8'hA3);
        push(3'd4, 8'hA4);
        rf_hold  = 1'b0;
        wb_valid = 1'b1;
        wb_addr  = 3'd6;
        wb_data  = 8'hB0;
        rd_addr_1 = 3'd6;
        #1;
        chk("nofwd_input", fwd_hit_1, 1'b0);
        tick();
        wr("w1", 3'd1, 8'hA1);
        chk("w1_pending", pending, 3'd4);
        chk("w1_ready", wb_ready, 1'b1);
        tick();
        wr("w2", 3'd2, 8'hA2);
        chk("w2_pending", pending, 3'd4);
        chk("w2_fwd", fwd_data_1, 8'hB0);
        wb_data = 8'hB1;
        tick();
        wr("w3", 3'd3, 8'hA3);
        wb_valid = 1'b0;
        tick();
        wr("w4", 3'd4, 8'hA4);
        tick();
        wr("w5", 3'd6, 8'hB0);
        chk("w5_fwd_young", fwd_data_1, 8'hB1);
        tick();
        wr("w6", 3'd6, 8'hB1);
        tick();
        chk("w7_we", rf_write_signal, 1'b0);
        chk("w7_idle", idle, 1'b1);

        // reset mid-flight cancels everything
        rf_hold = 1'b1;
        push(3'd1, 8'h10);
        push(3'd2, 8'h20);
        push(3'd3, 8'h30);
        rf_hold = 1'b0;
        tick();
        wr("pre_rst", 3'd1, 8'h10);
        chk("pre_rst_pending", pending, 3'd3);
        rd_addr_1 = 3'd2;
        #1;
        rst = 1'b1;
        #1;
        chk("ar_we", rf_write_signal, 1'b0);
        chk("ar_reg", rf_write_reg, 3'd0);
        chk("ar_data", rf_in_data, 8'h00);
        chk("ar_pending", pending, 3'd0);
        chk("ar_idle", idle, 1'b1);
        chk("ar_ready", wb_ready, 1'b1);
        chk("ar_fwd", fwd_hit_1, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_we", rf_write_signal, 1'b0);
        chk("post_rst_pending", pending, 3'd0);

        // first push after reset
        push(3'd7, 8'h77);
        chk("pr_pending", pending, 3'd1);
        tick();
        wr("pr", 3'd7, 8'h77);
        tick();
        chk("pr_idle", idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end
endmodule
